ads1299_frame_reader: RTL
=========================

# ads1299_frame_reader

Front-end acquisition stage that sits directly upstream of the IIR low-pass stage. It detects the ADS1299 DRDY falling edge and drives CS/SCLK to clock out one 216-bit data frame (24-bit status word plus 8 × 24-bit channel words). It then emits the selected channel, sign-extended to the filter's input width, as a single-cycle valid-qualified sample.

## Interface
- `Q_OUT`, default 64: output sample width; must be ≥ 24. Matches the filter input width.
- `CLK_DIV`, default 4: system clocks per SCLK half-period; must be ≥ 4 to cover the DOUT synchronizer delay.
- `clock`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-low.
- `enable`  in  1  when 0, no new frame is started.
- `ch_sel`  in  3  channel to forward (0..7); latched at frame start.
- `drdy_n`  in  1  ADC data-ready, asynchronous to `clock`.
- `dout`  in  1  ADC serial data, asynchronous to `clock`.
- `cs_n`  out  1  ADC chip select, active-low.
- `sclk`  out  1  ADC serial clock.
- `data_out`  out  Q_OUT  selected channel word, two's complement, sign-extended.
- `data_out_valid`  out  1  one-cycle pulse qualifying `data_out`.
- `status_out`  out  24  status word of the last completed frame.
- `overrun`  out  1  one-cycle pulse: DRDY edge arrived while not waiting for one.
- `busy`  out  1  high from frame start through the valid cycle.

## Operation
- Reset values: `cs_n`=1, `sclk`=0, `data_out`=0, `data_out_valid`=0, `status_out`=0, `overrun`=0, `busy`=0, state WAIT_DRDY.
- `drdy_n` and `dout` each pass through a 2-FF synchronizer.
- DRDY edge: the synchronized `drdy_n` goes from 1 in the previous cycle to 0 in the current cycle.
- States and transitions:
  - WAIT_DRDY: on DRDY edge with `enable`=1, go to CS_SETUP and latch `ch_sel`. With `enable`=0 the edge is ignored and does not count as an overrun.
  - CS_SETUP: `cs_n`=0, `sclk`=0, lasts CLK_DIV cycles, then SHIFT.
  - SHIFT: 216 bits, MSB first.
    - Per bit: `sclk`=1 for CLK_DIV cycles, then `sclk`=0 for CLK_DIV cycles.
    - Synchronized `dout` is sampled in the last `sclk`-high cycle of each bit.
    - 8-bit bit counter runs 0..215. After bit 215, go to CS_HOLD.
  - CS_HOLD: `cs_n`=0, `sclk`=0, lasts CLK_DIV cycles, then EMIT.
  - EMIT: one cycle.
    - `cs_n`=1, `data_out_valid`=1.
    - `data_out` and `status_out` update in this cycle.
    - Then go to WAIT_DRDY.
- Bit mapping:
  - Bits 0..23 form the status word.
  - Channel k occupies bits 24+24k .. 47+24k.
  - Only the status word and the latched channel are captured; the other channels are clocked out and discarded.
- Sign extension: `data_out` = {(Q_OUT-24) copies of word[23], word[23:0]}.
- `data_out` and `status_out` hold their values between frames.
- `enable` deasserted mid-frame: the current frame completes normally.
- DRDY edge in any state other than WAIT_DRDY: pulse `overrun` for 1 cycle, discard the edge, continue the current frame.
- Reset asserted mid-frame: all outputs return to reset values immediately. No `data_out_valid` for the aborted frame.

## Timing
- Let t0 be the first CS_SETUP cycle. `cs_n` falls at t0.
- First `sclk` rise at t0+CLK_DIV.
- 216 `sclk` periods of 2·CLK_DIV cycles each.
- `data_out_valid` at t0 + 2·CLK_DIV + 432·CLK_DIV. With CLK_DIV=4 this is t0+1736.
- `cs_n` rises in the EMIT cycle.
- t0 is 3 or 4 cycles after the physical `drdy_n` fall (2 synchronizer stages plus the edge register).
- `data_out_valid` is never high two cycles in a row.
- Minimum spacing between valid pulses is one full frame.

## Structure
- Shared package `ads1299_pkg`:
  - `WORD_BITS`=24, `N_CH`=8, `FRAME_BITS`=216.
  - State enum: WAIT_DRDY, CS_SETUP, SHIFT, CS_HOLD, EMIT.
- One sub-module, `drdy_sync`: 2-FF synchronizer plus falling-edge detector, also instantiated for `dout` with the edge output unused.
- Top level contains the FSM, the half-period counter, the bit counter and the capture registers.

## Test plan
- Reset, then idle 100 cycles with `drdy_n`=1: all outputs at reset values, `sclk` never toggles.
- ADC model with status 24'hC00000, channel 2 = 24'h7FFFFF, `ch_sel`=2: `data_out`=64'h0000_0000_007F_FFFF, `status_out`=24'hC00000, exactly one `data_out_valid` pulse.
- Channel 5 = 24'h800000, `ch_sel`=5, with `ch_sel` changed to 1 mid-frame: `data_out`=64'hFFFF_FFFF_FF80_0000 (the latched selection is used).
- CLK_DIV=4: exactly 216 `sclk` rising edges, period 8 cycles, `data_out_valid` at t0+1736, `cs_n` low throughout t0..t0+1735.
- Second DRDY fall during bit 100: one `overrun` pulse, single valid pulse with correct data, next DRDY edge starts a normal frame.
- Reset asserted at bit 100, then released: `cs_n`=1 and `sclk`=0 immediately, no valid pulse; the following DRDY edge yields a correct frame.

Source files
------------

// File: rtl/ads1299_pkg.sv
// Shared frame geometry and FSM state encoding for the ADS1299 reader.
package ads1299_pkg;

   localparam int WORD_BITS  = 24;
   localparam int N_CH       = 8;
   localparam int FRAME_BITS = 216;

   typedef enum logic [2:0] {
      WAIT_DRDY,
      CS_SETUP,
      SHIFT,
      CS_HOLD,
      EMIT
   } state_t;

   // Index of the first frame bit belonging to channel ch (status word comes first).
   function automatic logic [7:0] chan_first_bit(input logic [2:0] ch);
      return 8'(WORD_BITS + WORD_BITS * int'(ch));
   endfunction

endpackage

// File: rtl/ads1299_frame_reader_drdy_sync.sv
// Two-stage synchronizer for an asynchronous ADC pin plus a registered falling-edge detector.
module drdy_sync #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clock,
   input  logic reset,
   input  logic async_i,
   output logic sync_o,
   output logic fall_o
);

   logic meta_q;
   logic sync_q;
   logic prev_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
         prev_q <= RESET_VAL;
      end else begin
         meta_q <= async_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign sync_o = sync_q;
   assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/ads1299_frame_reader.sv
// Reads one 216-bit ADS1299 frame per DRDY fall and emits the selected channel sign-extended.
module ads1299_frame_reader
   import ads1299_pkg::*;
#(
   parameter int Q_OUT   = 64,
   parameter int CLK_DIV = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic [2:0]       ch_sel,
   input  logic             drdy_n,
   input  logic             dout,
   output logic             cs_n,
   output logic             sclk,
   output logic [Q_OUT-1:0] data_out,
   output logic             data_out_valid,
   output logic [23:0]      status_out,
   output logic             overrun,
   output logic             busy
);

   localparam int DIV_W = $clog2(CLK_DIV + 1);

   logic drdy_fall;
   logic drdy_level_unused;
   logic dout_s;
   logic dout_fall_unused;

   drdy_sync #(.RESET_VAL(1'b1)) u_drdy_sync (
      .clock   (clock),
      .reset   (reset),
      .async_i (drdy_n),
      .sync_o  (drdy_level_unused),
      .fall_o  (drdy_fall)
   );

   drdy_sync #(.RESET_VAL(1'b0)) u_dout_sync (
      .clock   (clock),
      .reset   (reset),
      .async_i (dout),
      .sync_o  (dout_s),
      .fall_o  (dout_fall_unused)
   );

   state_t                  state_q;
   logic [DIV_W-1:0]        div_q;
   logic [7:0]              bit_q;
   logic [2:0]              ch_q;
   logic [WORD_BITS-1:0]    stat_sh_q;
   logic [WORD_BITS-1:0]    chan_sh_q;
   logic                    cs_n_q;
   logic                    sclk_q;
   logic [Q_OUT-1:0]        data_q;
   logic                    valid_q;
   logic [WORD_BITS-1:0]    status_q;
   logic                    overrun_q;
   logic                    busy_q;

   logic                    div_last;
   logic                    in_status;
   logic                    in_chan;
   logic [7:0]              ch_lo;
   logic [Q_OUT-1:0]        data_d;

   assign div_last  = (div_q == DIV_W'(CLK_DIV - 1));
   assign ch_lo     = chan_first_bit(ch_q);
   assign in_status = (bit_q < 8'(WORD_BITS));
   assign in_chan   = (bit_q >= ch_lo) && (bit_q < ch_lo + 8'(WORD_BITS));
   assign data_d    = Q_OUT'($signed(chan_sh_q));

   // sclk_q doubles as the phase flag inside SHIFT: high half then low half of each bit.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= WAIT_DRDY;
         div_q     <= '0;
         bit_q     <= '0;
         ch_q      <= '0;
         stat_sh_q <= '0;
         chan_sh_q <= '0;
         cs_n_q    <= 1'b1;
         sclk_q    <= 1'b0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         status_q  <= '0;
         overrun_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         valid_q   <= 1'b0;
         overrun_q <= drdy_fall && (state_q != WAIT_DRDY);
         case (state_q)
            WAIT_DRDY: begin
               if (drdy_fall && enable) begin
                  state_q <= CS_SETUP;
                  cs_n_q  <= 1'b0;
                  sclk_q  <= 1'b0;
                  busy_q  <= 1'b1;
                  ch_q    <= ch_sel;
                  div_q   <= '0;
               end
            end
            CS_SETUP: begin
               if (div_last) begin
                  state_q <= SHIFT;
                  div_q   <= '0;
                  bit_q   <= '0;
                  sclk_q  <= 1'b1;
               end else begin
                  div_q <= div_q + 1'b1;
               end
            end
            SHIFT: begin
               if (!div_last) begin
                  div_q <= div_q + 1'b1;
               end else begin
                  div_q <= '0;
                  if (sclk_q) begin
                     sclk_q <= 1'b0;
                     if (in_status) stat_sh_q <= {stat_sh_q[WORD_BITS-2:0], dout_s};
                     if (in_chan)   chan_sh_q <= {chan_sh_q[WORD_BITS-2:0], dout_s};
                  end else if (bit_q == 8'(FRAME_BITS - 1)) begin
                     state_q <= CS_HOLD;
                  end else begin
                     bit_q  <= bit_q + 8'd1;
                     sclk_q <= 1'b1;
                  end
               end
            end
            CS_HOLD: begin
               if (div_last) begin
                  state_q  <= EMIT;
                  div_q    <= '0;
                  cs_n_q   <= 1'b1;
                  valid_q  <= 1'b1;
                  data_q   <= data_d;
                  status_q <= stat_sh_q;
               end else begin
                  div_q <= div_q + 1'b1;
               end
            end
            EMIT: begin
               state_q <= WAIT_DRDY;
               busy_q  <= 1'b0;
            end
            default: state_q <= WAIT_DRDY;
         endcase
      end
   end

   assign cs_n           = cs_n_q;
   assign sclk           = sclk_q;
   assign data_out       = data_q;
   assign data_out_valid = valid_q;
   assign status_out     = status_q;
   assign overrun        = overrun_q;
   assign busy           = busy_q;

endmodule
